// File: rtl/uart_px_pkg.sv
// Shared encodings and state types for the uart_px full-duplex UART.
package uart_px_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int MIN_BAUD_DIV = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Reserved encoding 3 behaves like "no parity".
  function automatic logic parity_on(input logic [1:0] mode);
    case (mode)
      PAR_EVEN, PAR_ODD: parity_on = 1'b1;
      PAR_NONE:          parity_on = 1'b0;
      default:           parity_on = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_px_bitclk.sv
// Loadable bit-period down-counter: tick fires when the count reaches zero,
// then reloads a full period from the divider captured at load time.
module uart_px_bitclk #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             half,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (load) begin
      div_d = div;
      cnt_d = half ? ((div >> 1) - 1'b1) : (div - 1'b1);
    end else if (cnt_q == '0) begin
      cnt_d = div_q - 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0) && !load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_px.sv
// Parametrised full-duplex UART with optional parity, 1/2 stop bits,
// mid-bit RX sampling, error/break/overrun reporting and ready/valid handshakes.
module uart_px #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_in,
  output logic                 tx_out,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);
  import uart_px_pkg::*;

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(MIN_BAUD_DIV);

  // Out-of-range dividers are clamped so the counters never wrap oddly.
  logic [DIV_W-1:0] baud_eff;
  assign baud_eff = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;

  // ---------------- TX ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_par_en_q, tx_par_en_d;
  logic                 tx_par_bit_q, tx_par_bit_d;
  logic                 tx_two_q, tx_two_d;
  logic                 tx_stop2_q, tx_stop2_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_load, tx_tick;

  uart_px_bitclk #(.DIV_W(DIV_W)) u_tx_bitclk (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tx_load),
    .half    (1'b0),
    .div     (baud_eff),
    .tick    (tx_tick)
  );

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_shift_d   = tx_shift_q;
    tx_idx_d     = tx_idx_q;
    tx_par_en_d  = tx_par_en_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_two_d     = tx_two_q;
    tx_stop2_d   = tx_stop2_q;
    tx_out_d     = tx_out_q;
    tx_load      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_load      = 1'b1;
          tx_shift_d   = tx_data;
          tx_par_en_d  = parity_on(parity_mode);
          tx_par_bit_d = (^tx_data) ^ (parity_mode == PAR_ODD);
          tx_two_d     = two_stop;
          tx_out_d     = 1'b0;
          tx_state_d   = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_out_d   = tx_shift_q[0];
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_idx_q == LAST_IDX) begin
            tx_stop2_d = 1'b0;
            if (tx_par_en_q) begin
              tx_out_d   = tx_par_bit_q;
              tx_state_d = TX_PARITY;
            end else begin
              tx_out_d   = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_out_d   = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_tick) begin
          tx_out_d   = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_two_q && !tx_stop2_q) begin
            tx_stop2_d = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        tx_out_d   = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q   <= TX_IDLE;
      tx_shift_q   <= '0;
      tx_idx_q     <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_two_q     <= 1'b0;
      tx_stop2_q   <= 1'b0;
      tx_out_q     <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_shift_q   <= tx_shift_d;
      tx_idx_q     <= tx_idx_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_par_bit_q <= tx_par_bit_d;
      tx_two_q     <= tx_two_d;
      tx_stop2_q   <= tx_stop2_d;
      tx_out_q     <= tx_out_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = (tx_state_q == TX_IDLE);

  // ---------------- RX ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic                 rx_par_en_q, rx_par_en_d;
  logic                 rx_odd_q, rx_odd_d;
  logic                 rx_par_bit_q, rx_par_bit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_break_q, rx_break_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_load, rx_tick;
  logic                 rx_perr_now, rx_is_break;

  uart_px_bitclk #(.DIV_W(DIV_W)) u_rx_bitclk (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (rx_load),
    .half    (1'b1),
    .div     (baud_eff),
    .tick    (rx_tick)
  );

  assign rx_perr_now = rx_par_en_q & (rx_par_bit_q ^ (^rx_shift_q) ^ rx_odd_q);
  // A break is an all-zero frame including a zero (or absent) parity bit.
  assign rx_is_break = ~rx_s_q & (rx_shift_q == '0) & (~rx_par_en_q | ~rx_par_bit_q);

  always_comb begin
    rx_meta_d    = rx_in;
    rx_s_d       = rx_meta_q;
    rx_prev_d    = rx_s_q;
    rx_state_d   = rx_state_q;
    rx_shift_d   = rx_shift_q;
    rx_idx_d     = rx_idx_q;
    rx_par_en_d  = rx_par_en_q;
    rx_odd_d     = rx_odd_q;
    rx_par_bit_d = rx_par_bit_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_perr_d    = rx_perr_q;
    rx_ferr_d    = rx_ferr_q;
    rx_break_d   = 1'b0;
    rx_ovr_d     = 1'b0;
    rx_load      = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_load      = 1'b1;
          rx_par_en_d  = parity_on(parity_mode);
          rx_odd_d     = (parity_mode == PAR_ODD);
          rx_par_bit_d = 1'b0;
          rx_state_d   = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_idx_d   = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == LAST_IDX) begin
            rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_par_bit_d = rx_s_q;
          rx_state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          if (rx_is_break) begin
            rx_break_d = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end else begin
            // Delivery wins over the pending word only if it is being consumed now.
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = rx_shift_q;
              rx_perr_d  = rx_perr_now;
              rx_ferr_d  = ~rx_s_q;
              rx_valid_d = 1'b1;
            end else begin
              rx_ovr_d = 1'b1;
            end
            rx_state_d = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q   <= RX_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_shift_q   <= '0;
      rx_idx_q     <= '0;
      rx_par_en_q  <= 1'b0;
      rx_odd_q     <= 1'b0;
      rx_par_bit_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_break_q   <= 1'b0;
      rx_ovr_q     <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      rx_shift_q   <= rx_shift_d;
      rx_idx_q     <= rx_idx_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_odd_q     <= rx_odd_d;
      rx_par_bit_q <= rx_par_bit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_perr_q    <= rx_perr_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_break_q   <= rx_break_d;
      rx_ovr_q     <= rx_ovr_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_break      = rx_break_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_px.sv
// Scoreboard bench for uart_px: an 8-bit instance driven serially by the bench
// and a 7-bit instance with tx_out looped back to rx_in.
module tb_uart_px;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;

  logic [15:0] baud8;
  logic [1:0]  par8;
  logic        two8;
  logic        rx_line;
  logic        tx_out8;
  logic        tx_valid8, tx_ready8;
  logic [7:0]  tx_data8;
  logic        rx_valid8, rx_ready8;
  logic [7:0]  rx_data8;
  logic        perr8, ferr8, brk8, ovr8;

  logic [15:0] baud7;
  logic [1:0]  par7;
  logic        two7;
  logic        tx_out7;
  logic        tx_valid7, tx_ready7;
  logic [6:0]  tx_data7;
  logic        rx_valid7, rx_ready7;
  logic [6:0]  rx_data7;
  logic        perr7, ferr7, brk7, ovr7;

  uart_px #(.DATA_BITS(8), .DIV_W(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .baud_div(baud8), .parity_mode(par8),
    .two_stop(two8), .rx_in(rx_line), .tx_out(tx_out8),
    .tx_valid(tx_valid8), .tx_ready(tx_ready8), .tx_data(tx_data8),
    .rx_valid(rx_valid8), .rx_ready(rx_ready8), .rx_data(rx_data8),
    .rx_parity_err(perr8), .rx_frame_err(ferr8),
    .rx_break(brk8), .rx_overrun(ovr8)
  );

  uart_px #(.DATA_BITS(7), .DIV_W(16)) dut7 (
    .clk(clk), .reset_n(reset_n), .baud_div(baud7), .parity_mode(par7),
    .two_stop(two7), .rx_in(tx_out7), .tx_out(tx_out7),
    .tx_valid(tx_valid7), .tx_ready(tx_ready7), .tx_data(tx_data7),
    .rx_valid(rx_valid7), .rx_ready(rx_ready7), .rx_data(rx_data7),
    .rx_parity_err(perr7), .rx_frame_err(ferr7),
    .rx_break(brk7), .rx_overrun(ovr7)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];
  exp_t e8, e7;

  int n_cmp = 0;
  int n_bad = 0;
  int rx8_events = 0;
  int brk_cnt = 0;
  int ovr_cnt = 0;

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
    exp_t r;
    r.data = d;
    r.perr = p;
    r.ferr = f;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_line = b;
    step(16);
  endtask

  // 8-bit frame at 16 clocks/bit; caller is positioned just after a rising edge.
  task automatic send_rx(input logic [7:0] d, input logic use_par, input logic pbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(pbit);
    drive_bit(1'b1);
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    step(n);
  endtask

  task automatic wait_q8(input string name);
    int n = 0;
    while (q8.size() != 0 && n < 2000) begin
      step(1);
      n++;
    end
    chk(name, 32'(q8.size()), 32'd0);
  endtask

  // Sends one 8N1 byte at baud 16 and checks first/last cycle of every bit
  // plus the exact tx_ready return at t+161.
  task automatic tx_check(input logic [7:0] d, input string tag);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    tx_data8  = d;
    tx_valid8 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid8 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (c == 0 || c == 15) chk($sformatf("%s_bit%0d_c%0d", tag, k, c), 32'(tx_out8), 32'(fr[k]));
        if (c == 15) chk($sformatf("%s_busy_bit%0d", tag, k), 32'(tx_ready8), 32'd0);
      end
    end
    @(negedge clk);
    chk({tag, "_ready_t161"}, 32'(tx_ready8), 32'd1);
    chk({tag, "_idle_line"}, 32'(tx_out8), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever an RX word is handed over.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (rx_valid8 && rx_ready8) begin
          rx8_events++;
          if (q8.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx8_unexpected: got data 0x%0h, expected no word", rx_data8);
          end else begin
            e8 = q8.pop_front();
            chk("rx8_data", 32'(rx_data8), 32'(e8.data));
            chk("rx8_parity_err", 32'(perr8), 32'(e8.perr));
            chk("rx8_frame_err", 32'(ferr8), 32'(e8.ferr));
          end
        end
        if (rx_valid7 && rx_ready7) begin
          if (q7.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx7_unexpected: got data 0x%0h, expected no word", rx_data7);
          end else begin
            e7 = q7.pop_front();
            chk("rx7_data", 32'(rx_data7), 32'(e7.data));
            chk("rx7_parity_err", 32'(perr7), 32'(e7.perr));
            chk("rx7_frame_err", 32'(ferr7), 32'(e7.ferr));
          end
        end
        if (brk7 || ovr7) chk("rx7_no_err_pulse", 32'({brk7, ovr7}), 32'd0);
        if (brk8) brk_cnt++;
        if (ovr8) ovr_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ev, b, o, n;
    reset_n   = 1'b0;
    rx_line   = 1'b1;
    baud8     = 16'd16;
    par8      = 2'd0;
    two8      = 1'b0;
    tx_valid8 = 1'b0;
    tx_data8  = 8'h00;
    rx_ready8 = 1'b1;
    baud7     = 16'd5;
    par7      = 2'd2;
    two7      = 1'b1;
    tx_valid7 = 1'b0;
    tx_data7  = 7'h00;
    rx_ready7 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_tx_out", 32'(tx_out8), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready8), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid8), 32'd0);
    chk("rst_rx_data", 32'(rx_data8), 32'd0);
    chk("rst_flags", 32'({perr8, ferr8, brk8, ovr8}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(4);

    // 8N1 TX of 0xA5
    tx_check(8'hA5, "tx_a5");

    // 7O2 loopback of 0x41: 11-bit frame at baud 5
    q7.push_back(mk(9'h041, 1'b0, 1'b0));
    tx_data7  = 7'h41;
    tx_valid7 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid7 = 1'b0;
    n = 0;
    while (!tx_ready7 && n < 200) begin
      step(1);
      n++;
    end
    chk("loop7_frame_cycles", 32'(n), 32'd55);
    n = 0;
    while (q7.size() != 0 && n < 500) begin
      step(1);
      n++;
    end
    chk("loop7_rx_done", 32'(q7.size()), 32'd0);
    step(10);

    // 8E1 byte 0x03 with wrong parity bit
    par8 = 2'd1;
    q8.push_back(mk(9'h003, 1'b1, 1'b0));
    send_rx(8'h03, 1'b1, 1'b1);
    idle(32);
    par8 = 2'd0;
    wait_q8("rx_parity_err_word");

    // 3-cycle glitch must not start a frame
    ev = rx8_events;
    rx_line = 1'b0;
    step(3);
    idle(320);
    chk("glitch_no_valid", 32'(rx8_events), 32'(ev));

    // 20 bit-times of low line: one break, no word, clean byte afterwards
    ev = rx8_events;
    b  = brk_cnt;
    rx_line = 1'b0;
    step(320);
    idle(48);
    chk("break_one_pulse", 32'(brk_cnt), 32'(b + 1));
    chk("break_no_valid", 32'(rx8_events), 32'(ev));
    q8.push_back(mk(9'h05A, 1'b0, 1'b0));
    send_rx(8'h5A, 1'b0, 1'b0);
    idle(32);
    wait_q8("rx_after_break");

    // Overrun: second frame dropped while the first is unconsumed
    rx_ready8 = 1'b0;
    o = ovr_cnt;
    send_rx(8'h11, 1'b0, 1'b0);
    idle(16);
    chk("ovr_first_valid", 32'(rx_valid8), 32'd1);
    chk("ovr_first_data", 32'(rx_data8), 32'h11);
    send_rx(8'h22, 1'b0, 1'b0);
    idle(16);
    chk("ovr_pulse_once", 32'(ovr_cnt), 32'(o + 1));
    chk("ovr_data_kept", 32'(rx_data8), 32'h11);
    q8.push_back(mk(9'h011, 1'b0, 1'b0));
    rx_ready8 = 1'b1;
    wait_q8("ovr_drain");
    step(4);

    // rx_ready only in the completion cycle of 0x22: new word loads, no overrun
    rx_ready8 = 1'b0;
    send_rx(8'h11, 1'b0, 1'b0);
    idle(16);
    o = ovr_cnt;
    q8.push_back(mk(9'h011, 1'b0, 1'b0));
    fork
      send_rx(8'h22, 1'b0, 1'b0);
      begin
        repeat (154) @(posedge clk);
        #1;
        rx_ready8 = 1'b1;
        @(posedge clk);
        #1;
        rx_ready8 = 1'b0;
      end
    join
    idle(16);
    chk("swap_valid", 32'(rx_valid8), 32'd1);
    chk("swap_data", 32'(rx_data8), 32'h22);
    chk("swap_no_overrun", 32'(ovr_cnt), 32'(o));
    q8.push_back(mk(9'h022, 1'b0, 1'b0));
    rx_ready8 = 1'b1;
    wait_q8("swap_drain");
    step(4);

    // Reset during data bit 4 of 0x0F (bit 4 is low)
    tx_data8  = 8'h0F;
    tx_valid8 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid8 = 1'b0;
    repeat (88) @(posedge clk);
    #3;
    chk("mid_bit4_low", 32'(tx_out8), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_out", 32'(tx_out8), 32'd1);
    chk("mid_rst_tx_ready", 32'(tx_ready8), 32'd1);
    chk("mid_rst_rx_valid", 32'(rx_valid8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(3);
    tx_check(8'hFF, "tx_ff");

    step(20);
    chk("final_q8_empty", 32'(q8.size()), 32'd0);
    chk("final_q7_empty", 32'(q7.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
